// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice chain and the shift-and-add multiply sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_S_ADD    = 4'b1001;
  localparam logic [3:0] ALU_S_PASS_A = 4'b1111;
  localparam logic       ALU_M_ARITH  = 1'b0;
  localparam logic       ALU_M_LOGIC  = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_STEP = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier control around an external 4-bit ALU slice chain.
// One partial-product step per cycle; product is {AR, MQ}.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int   W        = 36,
  parameter logic CIN_NONE = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [3:0]     alu_s,
  output logic           alu_m,
  output logic           alu_cin,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_f,
  input  logic           alu_cout,
  output logic           result_valid,
  input  logic           result_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int               CNT_W    = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);

  state_t           state_q, state_d;
  logic [W-1:0]     ar_q, ar_d;
  logic [W-1:0]     mq_q, mq_d;
  logic [W-1:0]     br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             add_step;
  logic             carry;

  // Only a STEP with MQ[0] set adds; every other cycle the chain passes A through.
  always_comb begin
    add_step = (state_q == ST_STEP) && mq_q[0];
    alu_s    = add_step ? ALU_S_ADD : ALU_S_PASS_A;
    alu_m    = add_step ? ALU_M_ARITH : ALU_M_LOGIC;
    alu_cin  = CIN_NONE;
    carry    = add_step & alu_cout;
  end

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    mq_d    = mq_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          br_d    = multiplicand;
          mq_d    = multiplier;
          ar_d    = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        // Carry-out lands in AR's MSB, so the 2W-bit product never overflows.
        {ar_d, mq_d} = {carry, alu_f, mq_q[W-1:1]};
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ar_q    <= '0;
      mq_q    <= '0;
      br_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      mq_q    <= mq_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_STEP);
  assign result_valid = (state_q == ST_DONE);
  assign product      = {ar_q, mq_q};
  assign alu_a        = ar_q;
  assign alu_b        = br_q;

endmodule
